msx_mouse_port: RTL and testbench

Converts host mouse reports into the MSX mouse protocol on one general-purpose joystick port. Sits between the MiST I/O mouse outputs (`mouse_x`/`mouse_y`/`mouse_flags`/`mouse_strobe`) and the Port A pins of the MSX core. It accumulates motion deltas between MSX reads with saturation, and serves 4-bit nibbles on each toggle of the MSX strobe pin (pin 8). It auto-enables on mouse activity and hands the port back to the joystick on joystick activity.

---
 rtl/msx_mouse_port_if.sv | 21 ++
 rtl/msx_mouse_port.sv | 126 ++++++++++++
 tb/tb_msx_mouse_port.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/msx_mouse_port_if.sv
// Signal bundle between the MiST host mouse / MSX core (master) and msx_mouse_port (slave).
interface msx_mouse_port_if;
  logic [8:0] mouse_x;
  logic [8:0] mouse_y;
  logic [7:0] mouse_flags;
  logic       mouse_strobe;
  logic       joy_active;
  logic       strobe_in;
  logic       mouse_en;
  logic [5:0] port_out;

  modport master (
    output mouse_x, mouse_y, mouse_flags, mouse_strobe, joy_active, strobe_in,
    input  mouse_en, port_out
  );

  modport slave (
    input  mouse_x, mouse_y, mouse_flags, mouse_strobe, joy_active, strobe_in,
    output mouse_en, port_out
  );
endinterface

// File: rtl/msx_mouse_port.sv
// MSX mouse protocol on one joystick port: saturating motion accumulation between reads,
// nibble serving on strobe toggles, auto handover between mouse and joystick.
module msx_mouse_port #(
  parameter int TIMEOUT = 100000
) (
  input logic               clk_sys,
  input logic               reset,
  msx_mouse_port_if.slave   io_mouse
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

  phase_t            r_phase;
  phase_t            w_phase_next;
  logic              r_mouse_en;
  logic              r_s_d;
  logic [CW-1:0]     r_cnt;
  logic signed [7:0] r_x_acc;
  logic signed [7:0] r_y_acc;
  logic signed [7:0] r_snap_x;
  logic signed [7:0] r_snap_y;
  logic [5:0]        r_port_out;

  logic              w_en_next;
  logic              w_edge;
  logic              w_snap;
  logic              w_expire;
  logic [3:0]        w_nibble;
  logic signed [7:0] w_x_base;
  logic signed [7:0] w_y_base;
  logic signed [9:0] w_x_diff;
  logic signed [9:0] w_y_sum;
  logic              w_unused_flags;

  function automatic logic signed [7:0] sat10(input logic signed [9:0] v);
    if (v > 10'sd127)       return 8'h7F;
    else if (v < -10'sd128) return 8'h80;
    else                    return v[7:0];
  endfunction

  // A mouse report keeps (or takes) ownership; joystick activity alone releases it.
  assign w_en_next = io_mouse.mouse_strobe | (r_mouse_en & ~io_mouse.joy_active);
  assign w_edge    = r_mouse_en & (r_s_d ^ io_mouse.strobe_in);
  assign w_snap    = w_edge && (r_phase == P0);
  assign w_expire  = (r_cnt == CW'(1));

  // A report arriving with the P0 snapshot lands in the freshly cleared accumulators.
  assign w_x_base = w_snap ? 8'sd0 : r_x_acc;
  assign w_y_base = w_snap ? 8'sd0 : r_y_acc;
  assign w_x_diff = {{2{w_x_base[7]}}, w_x_base} - {io_mouse.mouse_x[8], io_mouse.mouse_x};
  assign w_y_sum  = {{2{w_y_base[7]}}, w_y_base} + {io_mouse.mouse_y[8], io_mouse.mouse_y};

  assign w_unused_flags = ^io_mouse.mouse_flags[7:2];

  always_comb begin
    unique case (r_phase)
      P0:      w_nibble = r_x_acc[7:4];
      P1:      w_nibble = r_snap_x[3:0];
      P2:      w_nibble = r_snap_y[7:4];
      default: w_nibble = r_snap_y[3:0];
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) r_phase <= P0;
    else       r_phase <= w_phase_next;
  end

  // NOTE: default assigned first so every path drives w_phase_next and no latch is inferred.
  always_comb begin
    w_phase_next = r_phase;
    if (!w_en_next)    w_phase_next = P0;
    else if (w_edge)   w_phase_next = phase_t'(r_phase + 2'd1);
    else if (w_expire) w_phase_next = P0;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_mouse_en <= 1'b0;
      r_s_d      <= 1'b0;
      r_cnt      <= '0;
      r_x_acc    <= '0;
      r_y_acc    <= '0;
      r_snap_x   <= '0;
      r_snap_y   <= '0;
      r_port_out <= 6'h3F;
    end else begin
      r_s_d      <= io_mouse.strobe_in;
      r_mouse_en <= w_en_next;
      if (!w_en_next) begin
        r_cnt      <= '0;
        r_x_acc    <= '0;
        r_y_acc    <= '0;
        r_snap_x   <= '0;
        r_snap_y   <= '0;
        r_port_out <= 6'h3F;
      end else begin
        r_port_out[5:4] <= ~io_mouse.mouse_flags[1:0];
        if (w_edge) begin
          r_cnt           <= CW'(TIMEOUT);
          r_port_out[3:0] <= ~w_nibble;
        end else if (r_cnt != '0) begin
          r_cnt <= r_cnt - CW'(1);
        end
        if (w_snap) begin
          r_snap_x <= r_x_acc;
          r_snap_y <= r_y_acc;
        end
        if (io_mouse.mouse_strobe) begin
          r_x_acc <= sat10(w_x_diff);
          r_y_acc <= sat10(w_y_sum);
        end else if (w_snap) begin
          r_x_acc <= '0;
          r_y_acc <= '0;
        end
      end
    end
  end

  assign io_mouse.mouse_en = r_mouse_en;
  assign io_mouse.port_out = r_port_out;

endmodule

// File: tb/tb_msx_mouse_port.sv
// Self-checking bench for msx_mouse_port: directed scenarios plus random traffic against
// a transaction-level model built on integer accumulators and an idle-cycle count.
module tb_msx_mouse_port;

  localparam int TIMEOUT = 40;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  msx_mouse_port_if bus ();

  msx_mouse_port #(.TIMEOUT(TIMEOUT)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .io_mouse (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: signed accumulators as ints, phase 0..3, idle cycles since the last edge.
  int         m_x, m_y, m_sx, m_sy, m_phase, m_idle;
  bit         m_en, m_sd;
  logic [5:0] m_port;
  logic [7:0] g_flags;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int s9(input logic [8:0] v);
    return int'($signed(v));
  endfunction

  function automatic int clamp(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model_clear();
    m_x = 0; m_y = 0; m_sx = 0; m_sy = 0;
    m_phase = 0; m_idle = 0; m_port = 6'h3F;
  endtask

  task automatic model_step(input bit rep, input logic [8:0] x, input logic [8:0] y,
                            input logic [7:0] f, input bit joy);
    bit         edge_seen, en_next;
    logic [7:0] b;
    edge_seen = m_en && (m_sd != bus.strobe_in);
    m_sd      = bus.strobe_in;
    en_next   = rep || (m_en && !joy);
    if (!en_next) begin
      model_clear();
    end else begin
      if (edge_seen) begin
        if (m_idle >= TIMEOUT) m_phase = 0;
        case (m_phase)
          0: begin
            b = 8'(m_x);
            m_sx = m_x; m_sy = m_y; m_x = 0; m_y = 0;
            m_port[3:0] = ~b[7:4];
          end
          1: begin b = 8'(m_sx); m_port[3:0] = ~b[3:0]; end
          2: begin b = 8'(m_sy); m_port[3:0] = ~b[7:4]; end
          default: begin b = 8'(m_sy); m_port[3:0] = ~b[3:0]; end
        endcase
        m_phase = (m_phase + 1) % 4;
        m_idle  = 0;
      end else if (m_idle < 1000000) begin
        m_idle++;
      end
      if (rep) begin
        m_x = clamp(m_x - s9(x));
        m_y = clamp(m_y + s9(y));
      end
      m_port[5:4] = ~f[1:0];
    end
    m_en = en_next;
  endtask

  // One clock cycle: drive at a falling edge, sample at the next falling edge.
  task automatic cycle(input bit rep, input logic [8:0] x, input logic [8:0] y,
                       input bit tog, input bit joy, input string tag);
    bus.mouse_strobe = rep;
    bus.mouse_x      = x;
    bus.mouse_y      = y;
    bus.mouse_flags  = g_flags;
    bus.joy_active   = joy;
    if (tog) bus.strobe_in = ~bus.strobe_in;
    model_step(rep, x, y, g_flags, joy);
    @(negedge clk_sys);
    check({tag, "/en"}, 32'(bus.mouse_en), 32'(m_en));
    check({tag, "/port"}, 32'(bus.port_out), 32'(m_port));
    bus.mouse_strobe = 1'b0;
    bus.joy_active   = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 9'h0, 9'h0, 1'b0, 1'b0, tag);
  endtask

  task automatic report(input logic [8:0] x, input logic [8:0] y, input string tag);
    cycle(1'b1, x, y, 1'b0, 1'b0, tag);
  endtask

  task automatic toggle(input string tag);
    cycle(1'b0, 9'h0, 9'h0, 1'b1, 1'b0, tag);
  endtask

  // Four back-to-back strobe toggles; nibbles packed first-read in the top bits.
  task automatic read4(input string tag, output logic [15:0] nibs);
    nibs = '0;
    for (int i = 0; i < 4; i++) begin
      toggle(tag);
      nibs = {nibs[11:0], bus.port_out[3:0]};
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    model_clear();
    m_en = 1'b0;
    m_sd = 1'b0;
    @(negedge clk_sys);
    check({tag, "/en"}, 32'(bus.mouse_en), 32'h0);
    check({tag, "/port"}, 32'(bus.port_out), 32'h3F);
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] nibs;
    int          op;

    bus.mouse_x = '0; bus.mouse_y = '0; bus.mouse_flags = '0;
    bus.mouse_strobe = 1'b0; bus.joy_active = 1'b0; bus.strobe_in = 1'b0;
    g_flags = 8'h00;
    model_clear();
    m_en = 1'b0; m_sd = 1'b0;

    repeat (3) @(negedge clk_sys);
    do_reset("reset");

    // Basic read, then an empty read proving the accumulators were cleared.
    g_flags = 8'h02;
    report(9'h003, 9'h005, "enable");
    check("enable/en_high", 32'(bus.mouse_en), 32'h1);
    read4("basic", nibs);
    check("basic_read", 32'(nibs), 32'h02FA);
    read4("empty", nibs);
    check("empty_read", 32'(nibs), 32'hFFFF);

    // Saturation: X to +127, Y to -128.
    for (int i = 0; i < 6; i++) report(9'h19C, (i < 2) ? 9'h19C : 9'h000, "sat_acc");
    read4("sat", nibs);
    check("saturation", 32'(nibs), 32'h807F);

    // Timeout resync after a two-nibble partial read.
    report(9'h003, 9'h000, "to_prep");
    toggle("to_p0");
    toggle("to_p1");
    report(9'h1B0, 9'h000, "to_acc");
    idle(TIMEOUT + 1, "to_wait");
    toggle("to_resync");
    check("timeout_fresh_p0", 32'(bus.port_out[3:0]), 32'hA);
    for (int i = 0; i < 3; i++) toggle("to_finish");

    // Report in the same cycle as the P0 edge goes into the next read.
    cycle(1'b1, 9'h002, 9'h000, 1'b1, 1'b0, "simul_p0");
    check("simul_snap_excl", 32'(bus.port_out[3:0]), 32'hF);
    for (int i = 0; i < 3; i++) toggle("simul_rest");
    read4("simul_next", nibs);
    check("simul_next_read", 32'(nibs), 32'h01FF);

    // Edge in the expiry cycle still advances the phase.
    report(9'h1EB, 9'h000, "bnd_acc");
    toggle("bnd_p0");
    idle(TIMEOUT - 1, "bnd_wait");
    toggle("bnd_edge");
    check("expiry_edge_wins", 32'(bus.port_out[3:0]), 32'hA);
    toggle("bnd_p2");
    toggle("bnd_p3");

    // One cycle later the timeout has fired.
    report(9'h1EB, 9'h000, "bnd2_acc");
    toggle("bnd2_p0");
    idle(TIMEOUT, "bnd2_wait");
    toggle("bnd2_edge");
    check("expired_resync", 32'(bus.port_out[3:0]), 32'hF);
    for (int i = 0; i < 3; i++) toggle("bnd2_finish");

    // Handover to the joystick and back.
    cycle(1'b0, 9'h0, 9'h0, 1'b0, 1'b1, "joy");
    check("handover_en", 32'(bus.mouse_en), 32'h0);
    check("handover_port", 32'(bus.port_out), 32'h3F);
    toggle("joy_edge1");
    toggle("joy_edge2");
    check("handover_ignored", 32'(bus.port_out), 32'h3F);
    cycle(1'b1, 9'h0, 9'h0, 1'b0, 1'b1, "tie");
    check("tie_mouse_wins", 32'(bus.mouse_en), 32'h1);

    // Reset after the P1 nibble, then re-enable.
    report(9'h003, 9'h000, "rst_acc");
    toggle("rst_p0");
    toggle("rst_p1");
    do_reset("mid_reset");
    report(9'h010, 9'h000, "rst_reen");
    toggle("rst_first");
    check("reset_first_p0", 32'(bus.port_out[3:0]), 32'h0);
    for (int i = 0; i < 3; i++) toggle("rst_finish");

    // Random traffic against the model.
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 19);
      g_flags = 8'($urandom);
      if (op < 7)
        report(9'($urandom), 9'($urandom), "rnd_rep");
      else if (op < 12)
        cycle(1'($urandom), 9'($urandom), 9'($urandom), 1'b1, 1'b0, "rnd_tog");
      else if (op < 15)
        idle($urandom_range(TIMEOUT - 2, TIMEOUT + 2), "rnd_idle");
      else if (op < 16)
        cycle(1'b0, 9'h0, 9'h0, 1'b0, 1'b1, "rnd_joy");
      else
        read4("rnd_read", nibs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
